// File: rtl/fsab_dma_writer_pkg.sv
// FSAB bus widths, constants and the writer state type shared by the DMA write master and its bench.
package fsab_dma_writer_pkg;

    localparam int FSAB_REQ_HI     = 0;
    localparam int FSAB_DID_HI     = 3;
    localparam int FSAB_ADDR_HI    = 30;
    localparam int FSAB_LEN_HI     = 3;
    localparam int FSAB_DATA_HI    = 63;
    localparam int FSAB_MASK_HI    = 7;
    localparam int FSAB_CREDITS_HI = 3;

    localparam logic [FSAB_REQ_HI:0]     FSAB_REQ_WRITE       = 1'b1;
    localparam logic [FSAB_CREDITS_HI:0] FSAB_INITIAL_CREDITS = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dmaw_state_t;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered occupancy count.
module dma_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsab_dma_writer.sv
// Streaming FSAB write master: buffers producer words and issues fixed-length write bursts.
// Optional per-byte write mask through the FIFO when FSAB_DMA_WRITER_MASK_EN is defined.
module fsab_dma_writer
    import fsab_dma_writer_pkg::*;
#(
    parameter int                   BURST_LEN  = 8,
    parameter int                   FIFO_DEPTH = 16,
    parameter logic [FSAB_DID_HI:0] DID        = '0,
    parameter logic [FSAB_DID_HI:0] SUBDID     = '0
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     start,
    input  logic [FSAB_ADDR_HI:0]    base_addr,
    input  logic [15:0]              nbursts,
    input  logic                     in_valid,
    input  logic [FSAB_DATA_HI:0]    in_data,
`ifdef FSAB_DMA_WRITER_MASK_EN
    input  logic [FSAB_MASK_HI:0]    in_mask,
`endif
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output dmaw_state_t              debug_state,
    output logic                     dmaw__fsabo_valid,
    output logic [FSAB_REQ_HI:0]     dmaw__fsabo_mode,
    output logic [FSAB_DID_HI:0]     dmaw__fsabo_did,
    output logic [FSAB_DID_HI:0]     dmaw__fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]    dmaw__fsabo_addr,
    output logic [FSAB_LEN_HI:0]     dmaw__fsabo_len,
    output logic [FSAB_DATA_HI:0]    dmaw__fsabo_data,
    output logic [FSAB_MASK_HI:0]    dmaw__fsabo_mask,
    input  logic                     dmaw__fsabo_credit
);

    localparam int ADDR_W    = FSAB_ADDR_HI + 1;
    localparam int DATA_W    = FSAB_DATA_HI + 1;
    localparam int MASK_W    = FSAB_MASK_HI + 1;
    localparam int CRED_W    = FSAB_CREDITS_HI + 1;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WORDS_W   = 16 + BEAT_W;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
`ifdef FSAB_DMA_WRITER_MASK_EN
    localparam int FIFO_W    = DATA_W + MASK_W;
`else
    localparam int FIFO_W    = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN * 8);
    localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(63);

    dmaw_state_t          state_q;
    dmaw_state_t          state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [15:0]          remaining_q;
    logic [WORDS_W-1:0]   accepted_q;
    logic [WORDS_W-1:0]   total_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [CRED_W-1:0]    credits_q;
    logic                 zero_done_q;

    logic                 job_start;
    logic                 beat;
    logic                 last_beat;
    logic                 push;
    logic [FIFO_W-1:0]    fifo_in;
    logic [FIFO_W-1:0]    fifo_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign job_start = (state_q == ST_IDLE) && start && (nbursts != 16'd0);
    assign beat      = (state_q == ST_SEND);
    assign last_beat = beat && (beat_q == BEAT_W'(BURST_LEN - 1));
    assign in_ready  = (state_q != ST_IDLE) && !fifo_full && (accepted_q < total_q);
    assign push      = in_valid & in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE) || zero_done_q;
    assign debug_state = state_q;

`ifdef FSAB_DMA_WRITER_MASK_EN
    assign fifo_in = {in_mask, in_data};
`else
    assign fifo_in = in_data;
`endif

    dma_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (fifo_in),
        .pop       (beat && !fifo_empty),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (job_start) state_d = ST_FILL;
            ST_FILL: if (fifo_count >= CNT_W'(BURST_LEN) && credits_q >= CRED_W'(BURST_LEN))
                         state_d = ST_SEND;
            ST_SEND: if (last_beat) state_d = (remaining_q == 16'd1) ? ST_DONE : ST_FILL;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            accepted_q  <= '0;
            total_q     <= '0;
            beat_q      <= '0;
            credits_q   <= FSAB_INITIAL_CREDITS;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= (state_q == ST_IDLE) && start && (nbursts == 16'd0);
            if (job_start) begin
                addr_q      <= base_addr & ADDR_ALIGN;
                remaining_q <= nbursts;
                total_q     <= WORDS_W'(nbursts) * WORDS_W'(BURST_LEN);
                accepted_q  <= '0;
            end else if (push) begin
                accepted_q  <= accepted_q + WORDS_W'(1);
            end
            if (beat) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            if (last_beat) begin
                addr_q      <= addr_q + ADDR_STEP;
                remaining_q <= remaining_q - 16'd1;
            end
            // A beat and a returned credit in the same cycle cancel out.
            case ({beat, dmaw__fsabo_credit})
                2'b10:   credits_q <= credits_q - CRED_W'(1);
                2'b01:   if (credits_q != FSAB_INITIAL_CREDITS) credits_q <= credits_q + CRED_W'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    // A credit arriving with the pool already full means the arbiter returned more than was spent.
    always_ff @(posedge clk) begin
        if (rst_b && dmaw__fsabo_credit && !beat) assert (credits_q != FSAB_INITIAL_CREDITS);
    end

    // Idle slot drives zeros so the arbiter can OR requesters together.
    always_comb begin
        dmaw__fsabo_valid  = beat;
        dmaw__fsabo_mode   = '0;
        dmaw__fsabo_did    = '0;
        dmaw__fsabo_subdid = '0;
        dmaw__fsabo_addr   = '0;
        dmaw__fsabo_len    = '0;
        dmaw__fsabo_data   = '0;
        dmaw__fsabo_mask   = '0;
        if (beat) begin
            dmaw__fsabo_mode   = FSAB_REQ_WRITE;
            dmaw__fsabo_did    = DID;
            dmaw__fsabo_subdid = SUBDID;
            dmaw__fsabo_addr   = addr_q;
            dmaw__fsabo_len    = (FSAB_LEN_HI + 1)'(BURST_LEN);
            dmaw__fsabo_data   = fifo_out[DATA_W-1:0];
`ifdef FSAB_DMA_WRITER_MASK_EN
            dmaw__fsabo_mask   = fifo_out[FIFO_W-1 -: MASK_W];
`else
            dmaw__fsabo_mask   = '1;
`endif
        end
    end

endmodule

// File: tb/tb_fsab_dma_writer.sv
// Self-checking bench for fsab_dma_writer: producer driver, credit returner, beat scoreboard.
module tb_fsab_dma_writer;
    import fsab_dma_writer_pkg::*;

    localparam int BL   = 8;
    localparam int SB_W = (FSAB_ADDR_HI + 1) + (FSAB_DATA_HI + 1) + (FSAB_MASK_HI + 1);
`ifdef FSAB_DMA_WRITER_MASK_EN
    localparam logic [7:0] MASK_SEL = 8'h0F;
`else
    localparam logic [7:0] MASK_SEL = 8'hFF;
`endif

    logic                  clk = 1'b0;
    logic                  rst_b = 1'b0;
    logic                  start = 1'b0;
    logic [FSAB_ADDR_HI:0] base_addr = '0;
    logic [15:0]           nbursts = '0;
    logic                  in_valid = 1'b0;
    logic [FSAB_DATA_HI:0] in_data = '0;
`ifdef FSAB_DMA_WRITER_MASK_EN
    logic [FSAB_MASK_HI:0] in_mask = '1;
`endif
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    dmaw_state_t           debug_state;
    logic                  f_valid;
    logic [FSAB_REQ_HI:0]  f_mode;
    logic [FSAB_DID_HI:0]  f_did;
    logic [FSAB_DID_HI:0]  f_subdid;
    logic [FSAB_ADDR_HI:0] f_addr;
    logic [FSAB_LEN_HI:0]  f_len;
    logic [FSAB_DATA_HI:0] f_data;
    logic [FSAB_MASK_HI:0] f_mask;
    logic                  credit = 1'b0;

    logic [SB_W-1:0]       exp_q[$];
    int                    n_compared = 0;
    int                    n_mismatched = 0;
    logic [FSAB_ADDR_HI:0] job_base = '0;
    int                    job_words = 0;
    int                    total_beats = 0;
    int                    pending_credits = 0;
    bit                    credit_auto = 1'b1;
    int                    done_seen = 0;
    int                    done_target = 0;
    bit                    done_due = 1'b0;
    bit                    busy_exp = 1'b0;
    int                    beats_left = 0;

    fsab_dma_writer dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .start              (start),
        .base_addr          (base_addr),
        .nbursts            (nbursts),
        .in_valid           (in_valid),
        .in_data            (in_data),
`ifdef FSAB_DMA_WRITER_MASK_EN
        .in_mask            (in_mask),
`endif
        .in_ready           (in_ready),
        .busy               (busy),
        .done               (done),
        .debug_state        (debug_state),
        .dmaw__fsabo_valid  (f_valid),
        .dmaw__fsabo_mode   (f_mode),
        .dmaw__fsabo_did    (f_did),
        .dmaw__fsabo_subdid (f_subdid),
        .dmaw__fsabo_addr   (f_addr),
        .dmaw__fsabo_len    (f_len),
        .dmaw__fsabo_data   (f_data),
        .dmaw__fsabo_mask   (f_mask),
        .dmaw__fsabo_credit (credit)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [SB_W-1:0] e;
        if (!rst_b) begin
            check_val("reset_outs", {f_valid, busy, done, in_ready, f_mode, f_did, f_subdid,
                                     f_addr, f_len, f_data, f_mask}, '0);
            done_due   = 1'b0;
            busy_exp   = 1'b0;
            beats_left = 0;
        end else begin
            check_val("done", done, done_due);
            check_val("busy", busy, busy_exp);
            if (done) done_seen++;
            if (done_due) busy_exp = 1'b0;
            done_due = 1'b0;
            if (start && nbursts == 16'd0) done_due = 1'b1;
            if (start && nbursts != 16'd0) begin
                busy_exp   = 1'b1;
                beats_left = int'(nbursts) * BL;
            end
            if (f_valid) begin
                total_beats++;
                pending_credits++;
                check_val("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("beat_payload", {f_addr, f_data, f_mask}, e);
                end
                check_val("beat_header", {f_mode, f_did, f_subdid, f_len},
                          {FSAB_REQ_WRITE, 4'd0, 4'd0, 4'd8});
                beats_left--;
                if (beats_left == 0) done_due = 1'b1;
            end else begin
                check_val("idle_bus", {f_mode, f_did, f_subdid, f_addr, f_len, f_data, f_mask}, '0);
            end
        end
    end

    // Credit returner: hands back one credit per cycle for every beat seen
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_b && credit_auto && pending_credits > 0) begin
                credit = 1'b1;
                pending_credits--;
            end else begin
                credit = 1'b0;
            end
        end
    end

    task automatic start_job(input logic [FSAB_ADDR_HI:0] base, input logic [15:0] nb);
        job_base  = base & ~31'h3F;
        job_words = 0;
        if (nb != 16'd0) done_target++;
        else done_target++;
        base_addr = base;
        nbursts   = nb;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_words(input int n, input bit rand_data, input int mask_idx,
                              input int budget, output int accepted);
        logic [FSAB_ADDR_HI:0] a;
        logic [63:0]           d;
        logic [7:0]            m;
        bit                    need_new;
        accepted = 0;
        need_new = 1'b1;
        d = '0;
        m = 8'hFF;
        for (int c = 0; c < budget && accepted < n; c++) begin
            if (need_new) begin
                d = rand_data ? {$urandom(), $urandom()} : 64'(job_words);
                m = (accepted == mask_idx) ? MASK_SEL : 8'hFF;
                need_new = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = d;
`ifdef FSAB_DMA_WRITER_MASK_EN
            in_mask  = m;
`endif
            @(negedge clk);
            if (in_ready) begin
                a = job_base + 31'((job_words / BL) * BL * 8);
                exp_q.push_back({a, d, m});
                job_words++;
                accepted++;
                need_new = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_seen < done_target; c++) begin
            @(posedge clk);
            #1;
        end
        check_val("done_count", done_seen, done_target);
    endtask

    initial begin
        int acc;
        int b0;
        int n;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        check_val("reset_state", debug_state, ST_IDLE);

        // Single burst, sequential data, mask on word 2 when masks are built in
        start_job(31'h1000, 16'd1);
        push_words(8, 1'b0, 2, 100, acc);
        check_val("single_accepted", acc, 8);
        wait_done(100);

        // Zero-length job
        b0 = total_beats;
        start_job(31'h1000, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("zero_no_beats", total_beats, b0);
        check_val("zero_done", done_seen, done_target);

        // Credit starvation: first burst consumes all credits, then stall
        credit_auto = 1'b0;
        b0 = total_beats;
        start_job(31'h1000, 16'd3);
        push_words(24, 1'b1, -1, 200, acc);
        check_val("starve_accepted", acc, 24);
        repeat (30) @(posedge clk);
        #1;
        check_val("starve_beats", total_beats - b0, 8);
        check_val("starve_state", debug_state, ST_FILL);
        credit_auto = 1'b1;
        wait_done(300);
        repeat (12) @(posedge clk);
        #1;

        // Backpressure: only nbursts*BURST_LEN words are taken
        start_job(31'h2000, 16'd2);
        push_words(40, 1'b1, -1, 120, acc);
        check_val("bp_accepted", acc, 16);
        wait_done(100);

        // Address alignment and wrap at the top of the address space
        start_job(31'h7FFF_FFE5, 16'd2);
        push_words(16, 1'b1, -1, 200, acc);
        check_val("wrap_accepted", acc, 16);
        wait_done(100);
        repeat (12) @(posedge clk);
        #1;

        // Reset during beat 3 of a burst
        start_job(31'h3000, 16'd1);
        push_words(8, 1'b1, -1, 100, acc);
        n = 0;
        while (!f_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("burst_started", f_valid, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        credit_auto = 1'b0;
        rst_b = 1'b0;
        #1;
        check_val("async_reset", {f_valid, busy, done, in_ready, f_mode, f_did, f_subdid,
                                  f_addr, f_len, f_data, f_mask}, '0);
        exp_q.delete();
        done_target--;
        repeat (3) @(posedge clk);
        #1;
        pending_credits = 0;
        rst_b = 1'b1;
        credit_auto = 1'b1;
        check_val("post_reset_state", debug_state, ST_IDLE);
        check_val("post_reset_ready", in_ready, 1'b0);

        // Fresh job after reset
        start_job(31'h3000, 16'd1);
        push_words(8, 1'b1, -1, 100, acc);
        check_val("fresh_accepted", acc, 8);
        wait_done(100);
        repeat (12) @(posedge clk);
        #1;
        check_val("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
